// File: rtl/shrink_arbiter_pkg.sv
// Shared definitions for the two-requester sample-halving arbiter:
// source tags, default width and the reference halving arithmetic.
package shrink_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 32;
  // Widest sample the halving helper can process; WIDTH must not exceed it.
  localparam int MAX_WIDTH = 64;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  // Halve each signed half of a WIDTH-bit complex sample. Each half keeps
  // bits [half-1:1], which lands the sign bit in the magnitude field.
  // The upper two result bits are always zero.
  function automatic logic [MAX_WIDTH-1:0] shrink_sample(
    input logic [MAX_WIDTH-1:0] sample,
    input int                   width
  );
    logic [MAX_WIDTH+1:0] ext;
    logic [MAX_WIDTH-1:0] res;
    ext = {2'b00, sample};
    res = {MAX_WIDTH{1'b0}};
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < (width / 2) - 1) begin
        res[i] = ext[i+1];
      end else if (i < width - 2) begin
        res[i] = ext[i+2];
      end else begin
        res[i] = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/shrink_arbiter_if.sv
// Bundle of requester and consumer signals for shrink_arbiter.
// Grant counters exist only when SHRINK_ARB_STATS_EN is defined.
interface shrink_arbiter_if
  import shrink_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] in_a_data;
  logic             in_a_nd;
  logic             in_a_ready;
  logic [WIDTH-1:0] in_b_data;
  logic             in_b_nd;
  logic             in_b_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_nd;
  logic             out_src;
  logic             error;
`ifdef SHRINK_ARB_STATS_EN
  logic [15:0]      grant_cnt_a;
  logic [15:0]      grant_cnt_b;
`endif

  modport slave (
    input  in_a_data, in_a_nd, in_b_data, in_b_nd,
    output in_a_ready, in_b_ready, out_data, out_nd, out_src, error
`ifdef SHRINK_ARB_STATS_EN
    , output grant_cnt_a, grant_cnt_b
`endif
  );

  modport master (
    output in_a_data, in_a_nd, in_b_data, in_b_nd,
    input  in_a_ready, in_b_ready, out_data, out_nd, out_src, error
`ifdef SHRINK_ARB_STATS_EN
    , input grant_cnt_a, grant_cnt_b
`endif
  );

endinterface

// File: rtl/shrink_arbiter_hold.sv
// One-entry holding register for a single requester. A new sample may be
// loaded in the same cycle the held one is granted away.
module shrink_hold
  import shrink_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_nd,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_grant,
  output logic             o_full,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ovf
);

  logic             r_full;
  logic             r_ready;
  logic [WIDTH-1:0] r_data;
  logic             w_load;
  logic             w_full_nxt;

  // Load/overflow decision and next occupancy.
  always_comb begin
    w_load     = i_nd & (~r_full | i_grant);
    o_ovf      = i_nd & r_full & ~i_grant;
    w_full_nxt = r_full;
    if (w_load) begin
      w_full_nxt = 1'b1;
    end else if (i_grant) begin
      w_full_nxt = 1'b0;
    end else begin
      w_full_nxt = r_full;
    end
  end

  // Occupancy, ready flag and held sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
      r_data  <= {WIDTH{1'b0}};
    end else begin
      r_full  <= w_full_nxt;
      r_ready <= ~w_full_nxt;
      if (w_load) begin
        r_data <= i_data;
      end else begin
        r_data <= r_data;
      end
    end
  end

  assign o_full  = r_full;
  assign o_ready = r_ready;
  assign o_data  = r_data;

endmodule

// File: rtl/shrink_arbiter.sv
// Round-robin arbiter sharing one complex-sample halving datapath between
// two requesters. Define SHRINK_ARB_STATS_EN to add saturating grant counters.
module shrink_arbiter
  import shrink_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  shrink_arbiter_if.slave bus
);

  logic             w_full_a;
  logic             w_full_b;
  logic             w_ready_a;
  logic             w_ready_b;
  logic             w_ovf_a;
  logic             w_ovf_b;
  logic [WIDTH-1:0] w_data_a;
  logic [WIDTH-1:0] w_data_b;
  logic             w_grant_a;
  logic             w_grant_b;
  src_e             w_src;
  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] w_shrunk;

  src_e             r_last_grant;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_nd;
  src_e             r_out_src;
  logic             r_error;

  shrink_hold #(.WIDTH(WIDTH)) u_hold_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_nd    (bus.in_a_nd),
    .i_data  (bus.in_a_data),
    .i_grant (w_grant_a),
    .o_full  (w_full_a),
    .o_ready (w_ready_a),
    .o_data  (w_data_a),
    .o_ovf   (w_ovf_a)
  );

  shrink_hold #(.WIDTH(WIDTH)) u_hold_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_nd    (bus.in_b_nd),
    .i_data  (bus.in_b_data),
    .i_grant (w_grant_b),
    .o_full  (w_full_b),
    .o_ready (w_ready_b),
    .o_data  (w_data_b),
    .o_ovf   (w_ovf_b)
  );

  // Grant selection (contention goes to the requester not served last)
  // and halving of the granted sample.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (w_full_a && w_full_b) begin
      if (r_last_grant == SRC_B) begin
        w_grant_a = 1'b1;
      end else begin
        w_grant_b = 1'b1;
      end
    end else if (w_full_a) begin
      w_grant_a = 1'b1;
    end else if (w_full_b) begin
      w_grant_b = 1'b1;
    end else begin
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
    end
    w_src      = w_grant_b ? SRC_B : SRC_A;
    w_sel_data = w_grant_b ? w_data_b : w_data_a;
    w_shrunk   = WIDTH'(shrink_sample(MAX_WIDTH'(w_sel_data), WIDTH));
  end

  // Output register, round-robin pointer and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= SRC_B;
      r_out_data   <= {WIDTH{1'b0}};
      r_out_nd     <= 1'b0;
      r_out_src    <= SRC_A;
      r_error      <= 1'b0;
    end else begin
      r_out_nd <= w_grant_a | w_grant_b;
      r_error  <= r_error | w_ovf_a | w_ovf_b;
      if (w_grant_a || w_grant_b) begin
        r_last_grant <= w_src;
        r_out_data   <= w_shrunk;
        r_out_src    <= w_src;
      end else begin
        r_last_grant <= r_last_grant;
        r_out_data   <= r_out_data;
        r_out_src    <= r_out_src;
      end
    end
  end

  assign bus.in_a_ready = w_ready_a;
  assign bus.in_b_ready = w_ready_b;
  assign bus.out_data   = r_out_data;
  assign bus.out_nd     = r_out_nd;
  assign bus.out_src    = r_out_src;
  assign bus.error      = r_error;

`ifdef SHRINK_ARB_STATS_EN
  logic [15:0] r_grant_cnt_a;
  logic [15:0] r_grant_cnt_b;

  // Per-requester grant counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt_a <= 16'd0;
      r_grant_cnt_b <= 16'd0;
    end else begin
      if (w_grant_a && (r_grant_cnt_a != 16'hFFFF)) begin
        r_grant_cnt_a <= r_grant_cnt_a + 16'd1;
      end else begin
        r_grant_cnt_a <= r_grant_cnt_a;
      end
      if (w_grant_b && (r_grant_cnt_b != 16'hFFFF)) begin
        r_grant_cnt_b <= r_grant_cnt_b + 16'd1;
      end else begin
        r_grant_cnt_b <= r_grant_cnt_b;
      end
    end
  end

  assign bus.grant_cnt_a = r_grant_cnt_a;
  assign bus.grant_cnt_b = r_grant_cnt_b;
`endif

endmodule

// File: tb/tb_shrink_arbiter.sv
// Scoreboard bench for shrink_arbiter: directed vectors push hand-computed
// outputs (data, source, arrival cycle); a negedge monitor pops and compares.
module tb_shrink_arbiter;
  import shrink_arbiter_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] data;
    logic         src;
    int           cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   c;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  shrink_arbiter_if #(.WIDTH(W)) bus ();

  shrink_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic an, input logic [W-1:0] ad,
                       input logic bn, input logic [W-1:0] bd);
    @(posedge clk);
    #1;
    bus.in_a_nd   = an;
    bus.in_a_data = ad;
    bus.in_b_nd   = bn;
    bus.in_b_data = bd;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic expect_out(input logic [W-1:0] d, input logic s, input int at);
    sb.push_back('{data: d, src: s, cyc: at});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_a_nd = 1'b0;
    bus.in_b_nd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every out_nd pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (bus.out_nd === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%0h src=%0d expected=none (t=%0t)",
                 bus.out_data, bus.out_src, $time);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", 64'(bus.out_data), 64'(mon_e.data));
        check("out_src", 64'(bus.out_src), 64'(mon_e.src));
        check("out_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.in_a_nd   = 1'b0;
    bus.in_a_data = 32'h0;
    bus.in_b_nd   = 1'b0;
    bus.in_b_data = 32'h0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_nd", 64'(bus.out_nd), 64'h0);
    check("rst_out_data", 64'(bus.out_data), 64'h0);
    check("rst_out_src", 64'(bus.out_src), 64'h0);
    check("rst_error", 64'(bus.error), 64'h0);
    check("rst_ready_a", 64'(bus.in_a_ready), 64'h1);
    check("rst_ready_b", 64'(bus.in_b_ready), 64'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // A alone
    drive(1'b1, 32'h8000_0002, 1'b0, 32'h0);
    c = cyc;
    expect_out(32'h2000_0001, 1'b0, c + 2);
    idle(4);

    // B alone
    drive(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    c = cyc;
    expect_out(32'h3FFF_FFFF, 1'b1, c + 2);
    idle(4);

    // Simultaneous strobe after reset: A first, B one cycle later
    do_reset();
    drive(1'b1, 32'h0004_0006, 1'b1, 32'h7FFE_FFFC);
    c = cyc;
    expect_out(32'h0001_0003, 1'b0, c + 2);
    expect_out(32'h1FFF_FFFE, 1'b1, c + 3);
    idle(1);
    check("contend_ready_a_low", 64'(bus.in_a_ready), 64'h0);
    check("contend_ready_b_low", 64'(bus.in_b_ready), 64'h0);
    idle(4);
    check("contend_ready_a_high", 64'(bus.in_a_ready), 64'h1);
    check("contend_ready_b_high", 64'(bus.in_b_ready), 64'h1);

    // A back-to-back for three cycles: grant and reload in the same cycle
    drive(1'b1, 32'h0002_0002, 1'b0, 32'h0);
    c = cyc;
    expect_out(32'h0000_8001, 1'b0, c + 2);
    expect_out(32'h0004_0010, 1'b0, c + 3);
    expect_out(32'h3FFF_8000, 1'b0, c + 4);
    drive(1'b1, 32'h0010_0020, 1'b0, 32'h0);
    drive(1'b1, 32'hFFFE_0000, 1'b0, 32'h0);
    idle(5);
    check("burst_error", 64'(bus.error), 64'h0);
`ifdef SHRINK_ARB_STATS_EN
    check("burst_cnt_a", 64'(bus.grant_cnt_a), 64'd4);
    check("burst_cnt_b", 64'(bus.grant_cnt_b), 64'd1);
`endif

    // Both strobe every cycle: b1, a2, b3 hit a full, ungranted register
    do_reset();
    drive(1'b1, 32'h0010_0010, 1'b1, 32'h0100_0100);
    c = cyc;
    expect_out(32'h0004_0008, 1'b0, c + 2);
    expect_out(32'h0040_0080, 1'b1, c + 3);
    expect_out(32'h0008_0010, 1'b0, c + 4);
    expect_out(32'h0080_0100, 1'b1, c + 5);
    expect_out(32'h0010_0020, 1'b0, c + 6);
    drive(1'b1, 32'h0020_0020, 1'b1, 32'h0150_0150);
    drive(1'b1, 32'h0030_0030, 1'b1, 32'h0200_0200);
    drive(1'b1, 32'h0040_0040, 1'b1, 32'h0250_0250);
    idle(6);
    check("ovf_error", 64'(bus.error), 64'h1);
`ifdef SHRINK_ARB_STATS_EN
    check("ovf_cnt_a", 64'(bus.grant_cnt_a), 64'd3);
    check("ovf_cnt_b", 64'(bus.grant_cnt_b), 64'd2);
`endif

    // Reset while both registers are full: held samples must vanish
    drive(1'b1, 32'h1234_5678, 1'b1, 32'h0ABC_DEF0);
    idle(1);
    rst_n = 1'b0;
    bus.in_a_nd = 1'b0;
    bus.in_b_nd = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(6);
    check("midrst_error", 64'(bus.error), 64'h0);
    check("midrst_ready_a", 64'(bus.in_a_ready), 64'h1);
    check("midrst_ready_b", 64'(bus.in_b_ready), 64'h1);
    check("midrst_out_nd", 64'(bus.out_nd), 64'h0);
`ifdef SHRINK_ARB_STATS_EN
    check("midrst_cnt_a", 64'(bus.grant_cnt_a), 64'd0);
    check("midrst_cnt_b", 64'(bus.grant_cnt_b), 64'd0);
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
    end
    check("scoreboard_drained", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
